// File: rtl/teras_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : teras_result_fifo
// Purpose  : Buffers result words leaving the teras systolic array and serves
//            them to the Wishbone bridge through a request/acknowledge read
//            port. Applies real backpressure to teras through rtr_o.
//
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            rts_i/rtr_o/data_i - result stream from teras (valid/ready/data)
//            rd_req_i          - read request, held by the bridge until ack
//            rd_sel_i          - 0 = pop data word, 1 = status word (option)
//            rd_ack_o          - one-cycle read acknowledge
//            rd_dat_o          - read data, valid while rd_ack_o is high
//            count_o           - current occupancy
//            empty_o / full_o  - occupancy flags
//
// Option   : TERAS_RESULT_FIFO_STATUS_EN - when defined, rd_sel_i = 1 returns
//            {underflow, full, empty, 0.., count} and clears underflow.
//            When undefined, every read is a data pop.
//
// Revision : 1.0 - initial release
// ============================================================================
module teras_result_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rts_i,
  output logic              rtr_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_req_i,
  input  logic              rd_sel_i,
  output logic              rd_ack_o,
  output logic [31:0]       rd_dat_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam logic [0:0]      S_IDLE   = 1'b0;
  localparam logic [0:0]      S_ACK    = 1'b1;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       dat_q, dat_d;
  logic              underflow_q, underflow_d;
  logic [0:0]        state_q, state_d;

  // --------------------------------------------------------------------------
  // Flags and handshakes
  // --------------------------------------------------------------------------
  logic        full_w;
  logic        empty_w;
  logic        push;
  logic        rd_take;
  logic        rd_is_status;
  logic        pop;
  logic [31:0] rd_word;
  logic [31:0] status_word;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // rtr_o comes only from the registered count, so a pop at full does not
  // open the input in the same cycle.
  assign push    = rts_i & ~full_w;

  // A request is only accepted in IDLE; while ACK is shown the held request
  // is ignored so each request yields exactly one ack and at most one pop.
  assign rd_take = (state_q == S_IDLE) & rd_req_i;

`ifdef TERAS_RESULT_FIFO_STATUS_EN
  assign rd_is_status = rd_sel_i;

  always_comb begin
    status_word              = '0;
    status_word[31]          = underflow_q;
    status_word[30]          = full_w;
    status_word[29]          = empty_w;
    status_word[ADDR_W:0]    = count_q;
  end
`else
  // Without the status option the select line has no effect.
  logic unused_rd_sel;
  assign unused_rd_sel = rd_sel_i;
  assign rd_is_status  = 1'b0;
  assign status_word   = '0;
`endif

  assign pop = rd_take & ~rd_is_status & ~empty_w;

  // Zero-extend the stored word to the 32-bit bus.
  always_comb begin
    rd_word               = '0;
    rd_word[DATA_W-1:0]   = mem_q[rd_ptr_q];
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dat_d       = dat_q;
    underflow_d = underflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (rd_take) begin
      if (rd_is_status) begin
        dat_d       = status_word;
        underflow_d = 1'b0;
      end else if (!empty_w) begin
        dat_d    = rd_word;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        // Reading an empty FIFO still completes the bus cycle with zero data.
        dat_d       = '0;
        underflow_d = 1'b1;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dat_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dat_q       <= dat_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rd_req_i) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ack_o = 1'b0;
    case (state_q)
      S_ACK:   rd_ack_o = 1'b1;
      default: rd_ack_o = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rd_dat_o = dat_q;
  assign count_o  = count_q;
  assign empty_o  = empty_w;
  assign full_o   = full_w;
  assign rtr_o    = ~full_w;

endmodule
`default_nettype wire
